// File: rtl/seg_scan_module_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_scan_module_if                                               |
// | Application, encoder and pin signals of the 7-segment scanner.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface seg_scan_module_if #(
  parameter int DIGITS = 6
);
  logic [4*DIGITS-1:0] i_data;
  logic                i_load;
  logic [DIGITS-1:0]   i_blank;
  logic                o_ready;
  logic [3:0]          o_nibble;
  logic [7:0]          i_seg;
  logic [7:0]          o_seg;
  logic [DIGITS-1:0]   o_dig;

  modport master (
    output i_data, i_load, i_blank, i_seg,
    input  o_ready, o_nibble, o_seg, o_dig
  );

  modport slave (
    input  i_data, i_load, i_blank, i_seg,
    output o_ready, o_nibble, o_seg, o_dig
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_module.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_scan_module                                                  |
// | Multiplexed common-anode 7-seg scanner sharing one hex encoder,  |
// | double-buffered display. Option macro: SEG_LZ_SUPPRESS_EN.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seg_scan_module #(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 16
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_module_if.slave bus
);

  localparam int c_cnt_w = $clog2(SCAN_DIV);
  localparam int c_idx_w = $clog2(DIGITS);

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_dead_last = c_cnt_w'(DEAD - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DIGITS - 1);

  localparam logic [0:0] c_st_blank = 1'b0;
  localparam logic [0:0] c_st_drive = 1'b1;

  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_idx_w-1:0]    r_idx;
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [DIGITS-1:0][3:0] r_disp;
  logic [DIGITS-1:0][3:0] r_pend;
  logic                  r_pend_vld;
  logic [3:0]            r_nibble;
  logic [7:0]            r_seg;

  logic                  w_cnt_last;
  logic                  w_frame_end;
  logic [DIGITS-1:0]     w_lz;
  logic [DIGITS-1:0]     w_blank;
  logic [DIGITS-1:0]     w_onehot;
  logic                  w_show;

  assign w_cnt_last  = (r_cnt == c_cnt_last);
  assign w_frame_end = w_cnt_last && (r_idx == c_idx_last);

`ifdef SEG_LZ_SUPPRESS_EN
  logic w_zero_run;

  // Digit 0 is never suppressed so an all-zero value still shows "0".
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run && (r_disp[k] == 4'h0);
      w_lz[k]    = w_zero_run;
    end
  end
`else
  assign w_lz = '0;
`endif

  assign w_blank  = bus.i_blank | w_lz;
  assign w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
  assign w_show   = (r_state == c_st_drive) && !w_blank[r_idx];

  always_comb begin
    w_state_nxt = r_state;
    if (w_cnt_last) begin
      w_state_nxt = c_st_blank;
    end else if (r_cnt == c_dead_last) begin
      w_state_nxt = c_st_drive;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= c_st_blank;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_last) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Nibble is latched at slot start so the encoder settles during dead time;
  // segments follow the state being entered so they blank with the digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nibble <= 4'h0;
      r_seg    <= 8'hFF;
    end else begin
      if (r_cnt == '0) begin
        r_nibble <= r_disp[r_idx];
      end
      r_seg <= ((w_state_nxt == c_st_drive) && !w_blank[r_idx]) ? bus.i_seg : 8'hFF;
    end
  end

  // A load on the frame-end cycle refills pending after the swap, so ready stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_frame_end && r_pend_vld) begin
        r_disp <= r_pend;
      end
      if (bus.i_load) begin
        r_pend     <= bus.i_data;
        r_pend_vld <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign bus.o_ready  = ~r_pend_vld;
  assign bus.o_nibble = r_nibble;
  assign bus.o_seg    = r_seg;
  assign bus.o_dig    = w_show ? ~w_onehot : '1;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_module.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for seg_scan_module (DIGITS=4, SCAN_DIV=8, DEAD=2).
module tb_seg_scan_module;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEAD     = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  seg_scan_module_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_module #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .DEAD    (DEAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 8'hC0; 4'h1: enc = 8'hF9; 4'h2: enc = 8'hA4; 4'h3: enc = 8'hB0;
      4'h4: enc = 8'h99; 4'h5: enc = 8'h92; 4'h6: enc = 8'h82; 4'h7: enc = 8'hF8;
      4'h8: enc = 8'h80; 4'h9: enc = 8'h90; 4'hA: enc = 8'h88; 4'hB: enc = 8'h83;
      4'hC: enc = 8'hC6; 4'hD: enc = 8'hA1; 4'hE: enc = 8'h86; default: enc = 8'h8E;
    endcase
  endfunction

  assign bus.i_seg = enc(bus.o_nibble);

  // Reference model: cycle count since reset plus the two value buffers.
  int          t;
  logic [15:0] m_disp, m_pend;
  logic        m_pv;
  logic [15:0] tmp_d, tmp_p;
  logic        tmp_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= 0; m_disp <= '0; m_pend <= '0; m_pv <= 1'b0;
    end else begin
      tmp_d = m_disp; tmp_p = m_pend; tmp_v = m_pv;
      if ((t % FRAME) == FRAME - 1 && tmp_v) begin
        tmp_d = tmp_p;
        tmp_v = 1'b0;
      end
      if (bus.i_load) begin
        tmp_p = bus.i_data;
        tmp_v = 1'b1;
      end
      t <= t + 1; m_disp <= tmp_d; m_pend <= tmp_p; m_pv <= tmp_v;
    end
  end

  function automatic logic [3:0] nib(input logic [15:0] d, input int s);
    logic [15:0] sh;
    sh = d >> (4 * s);
    return sh[3:0];
  endfunction

  function automatic bit lz_blank(input int s, input logic [15:0] d);
`ifdef SEG_LZ_SUPPRESS_EN
    return (s >= 1) && ((d >> (4 * s)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit lit(input int tt, input logic [3:0] blank, input logic [15:0] d);
    int s;
    s = (tt / SCAN_DIV) % DIGITS;
    return ((tt % SCAN_DIV) >= DEAD) && !blank[s] && !lz_blank(s, d);
  endfunction

  function automatic logic [3:0] exp_dig(input int tt, input logic [3:0] blank, input logic [15:0] d);
    logic [3:0] one;
    one = 4'b0001;
    return lit(tt, blank, d) ? ~(one << ((tt / SCAN_DIV) % DIGITS)) : 4'hF;
  endfunction

  function automatic logic [7:0] exp_seg(input int tt, input logic [3:0] blank, input logic [15:0] d);
    return lit(tt, blank, d) ? enc(nib(d, (tt / SCAN_DIV) % DIGITS)) : 8'hFF;
  endfunction

  // Continuous check of every output against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      n_checks++;
      if (bus.o_dig !== exp_dig(t, bus.i_blank, m_disp)) begin
        n_fail++;
        $display("FAIL mon_dig t=%0d got %b exp %b", t, bus.o_dig, exp_dig(t, bus.i_blank, m_disp));
      end
      n_checks++;
      if (bus.o_seg !== exp_seg(t, bus.i_blank, m_disp)) begin
        n_fail++;
        $display("FAIL mon_seg t=%0d got %h exp %h", t, bus.o_seg, exp_seg(t, bus.i_blank, m_disp));
      end
      n_checks++;
      if (bus.o_ready !== !m_pv) begin
        n_fail++;
        $display("FAIL mon_ready t=%0d got %b exp %b", t, bus.o_ready, !m_pv);
      end
      if ((t % SCAN_DIV) >= 1) begin
        n_checks++;
        if (bus.o_nibble !== nib(m_disp, (t / SCAN_DIV) % DIGITS)) begin
          n_fail++;
          $display("FAIL mon_nibble t=%0d got %h exp %h", t, bus.o_nibble, nib(m_disp, (t / SCAN_DIV) % DIGITS));
        end
      end
      n_checks++;
      if ($countones(~bus.o_dig) > 1 || ((t % SCAN_DIV) < DEAD && bus.o_dig !== 4'hF)) begin
        n_fail++;
        $display("FAIL mon_dig_rule t=%0d got %b exp at most one low, none in blank", t, bus.o_dig);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] d);
    bus.i_data = d;
    bus.i_load = 1'b1;
    step();
    bus.i_load = 1'b0;
  endtask

  task automatic wait_mod(input int m);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((t % FRAME) == m) begin hit = 1'b1; break; end
      step();
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL wait_mod timeout got pos %0d exp %0d", t % FRAME, m);
    end
  endtask

  task automatic wait_ready();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (bus.o_ready === 1'b1) begin hit = 1'b1; break; end
      step();
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready timeout got %b exp 1", bus.o_ready);
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    bit chk;
    bus.i_data = '0; bus.i_load = 1'b0; bus.i_blank = '0;
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.o_dig !== 4'hF) begin n_fail++; $display("FAIL rst_dig got %b exp 1111", bus.o_dig); end
    n_checks++; if (bus.o_seg !== 8'hFF) begin n_fail++; $display("FAIL rst_seg got %h exp ff", bus.o_seg); end
    n_checks++; if (bus.o_nibble !== 4'h0) begin n_fail++; $display("FAIL rst_nibble got %h exp 0", bus.o_nibble); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.o_ready); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      chk = 1'b1;
      e = 4'hF;
      case (c)
        0, 1, 8, 9: e = 4'hF;
        2, 7, 34:   e = 4'b1110;
        10:         e = 4'b1101;
        18:         e = 4'b1011;
        26:         e = 4'b0111;
        default:    chk = 1'b0;
      endcase
      if (chk) begin
        n_checks++;
        if (bus.o_dig !== e) begin n_fail++; $display("FAIL scan_dig cycle=%0d got %b exp %b", c, bus.o_dig, e); end
      end
      if (c == 1) begin
        n_checks++;
        if (bus.o_seg !== 8'hFF) begin n_fail++; $display("FAIL scan_seg_blank got %h exp ff", bus.o_seg); end
      end
    end
    step();
  endtask

  task automatic test_load(input logic [15:0] d);
    logic [7:0] es;
    wait_ready();
    repeat ($urandom_range(0, 20)) step();
    pulse_load(d);
    n_checks++;
    if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_low got %b exp 0", bus.o_ready); end
    wait_ready();
    n_checks++;
    if ((t % FRAME) != 0) begin n_fail++; $display("FAIL load_ready_rise pos got %0d exp 0", t % FRAME); end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if ((c % SCAN_DIV) == 1) begin
        n_checks++;
        if (bus.o_nibble !== nib(d, c / SCAN_DIV)) begin
          n_fail++; $display("FAIL load_nibble slot=%0d got %h exp %h", c / SCAN_DIV, bus.o_nibble, nib(d, c / SCAN_DIV));
        end
      end
      if ((c % SCAN_DIV) == 3) begin
        es = lz_blank(c / SCAN_DIV, d) ? 8'hFF : enc(nib(d, c / SCAN_DIV));
        n_checks++;
        if (bus.o_seg !== es) begin n_fail++; $display("FAIL load_seg slot=%0d got %h exp %h", c / SCAN_DIV, bus.o_seg, es); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int seen_a, not5;
    seen_a = 0; not5 = 0;
    wait_ready();
    wait_mod(1);
    pulse_load(16'hAAAA);
    repeat ($urandom_range(1, 15)) step();
    pulse_load(16'h5555);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (bus.o_nibble === 4'hA) seen_a++;
      step();
    end
    wait_mod(0);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if ((c % SCAN_DIV) >= 1 && bus.o_nibble !== 4'h5) not5++;
      step();
    end
    n_checks++; if (seen_a != 0) begin n_fail++; $display("FAIL b2b_aaaa_seen got %0d exp 0", seen_a); end
    n_checks++; if (not5 != 0) begin n_fail++; $display("FAIL b2b_5555_shown got %0d exp 0 other nibbles", not5); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", bus.o_ready); end
  endtask

  task automatic test_blank();
    int bad_dig, bad_seg;
    logic [3:0] d1;
    bad_dig = 0; bad_seg = 0; d1 = 4'hF;
    wait_mod(0);
    bus.i_blank = 4'b0100;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (bus.o_dig[2] !== 1'b1) bad_dig++;
      if ((c / SCAN_DIV) == 2 && bus.o_seg !== 8'hFF) bad_seg++;
      if (c == 12) d1 = bus.o_dig;
      step();
    end
    n_checks++; if (bad_dig != 0) begin n_fail++; $display("FAIL blank_dig2 got %0d low cycles exp 0", bad_dig); end
    n_checks++; if (bad_seg != 0) begin n_fail++; $display("FAIL blank_seg2 got %0d lit cycles exp 0", bad_seg); end
    n_checks++; if (d1 !== 4'b1101) begin n_fail++; $display("FAIL blank_dig1 got %b exp 1101", d1); end
    wait_mod(0);
    bus.i_blank = '0;
  endtask

  task automatic test_boundary_load();
    logic [15:0] v1, v2;
    v1 = 16'($urandom);
    v2 = {16'($urandom) & 16'hFFF0} | {12'h0, v1[3:0] ^ 4'h5};
    wait_ready();
    wait_mod(10);
    pulse_load(v1);
    wait_mod(FRAME - 1);
    pulse_load(v2);
    n_checks++;
    if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bnd_ready got %b exp 0", bus.o_ready); end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.o_nibble !== v1[3:0]) begin n_fail++; $display("FAIL bnd_old_shown got %h exp %h", bus.o_nibble, v1[3:0]); end
    wait_ready();
    step();
    @(negedge clk);
    n_checks++;
    if (bus.o_nibble !== v2[3:0]) begin n_fail++; $display("FAIL bnd_new_shown got %h exp %h", bus.o_nibble, v2[3:0]); end
  endtask

  task automatic test_lz();
    logic [3:0] lit_mask, e;
    logic [7:0] s0, s1;
    for (int pass = 0; pass < 2; pass++) begin
      lit_mask = 4'h0; s0 = 8'h00; s1 = 8'h00;
      wait_ready();
      pulse_load((pass == 0) ? 16'h0070 : 16'h0000);
      wait_ready();
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        lit_mask = lit_mask | ~bus.o_dig;
        if (c == 3) s0 = bus.o_seg;
        if (c == 11) s1 = bus.o_seg;
        step();
      end
`ifdef SEG_LZ_SUPPRESS_EN
      e = (pass == 0) ? 4'b0011 : 4'b0001;
`else
      e = 4'b1111;
`endif
      n_checks++; if (lit_mask !== e) begin n_fail++; $display("FAIL lz_lit pass=%0d got %b exp %b", pass, lit_mask, e); end
      n_checks++; if (s0 !== 8'hC0) begin n_fail++; $display("FAIL lz_digit0 pass=%0d got %h exp c0", pass, s0); end
      if (pass == 0) begin
        n_checks++; if (s1 !== 8'hF8) begin n_fail++; $display("FAIL lz_digit1 got %h exp f8", s1); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ((t % FRAME) == 0 && $urandom_range(0, 1) == 1) bus.i_blank = 4'($urandom);
      if ($urandom_range(0, 9) == 0) pulse_load(16'($urandom));
      else step();
    end
    wait_mod(0);
    bus.i_blank = '0;
  endtask

  task automatic test_midslot_reset();
    wait_ready();
    pulse_load(16'h9876);
    wait_ready();
    pulse_load(16'h4321);
    wait_mod(2 * SCAN_DIV + 5);
    #2;
    n_checks++;
    if (bus.o_dig !== 4'b1011) begin n_fail++; $display("FAIL mrst_pre_dig got %b exp 1011", bus.o_dig); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.o_dig !== 4'hF) begin n_fail++; $display("FAIL mrst_dig got %b exp 1111", bus.o_dig); end
    n_checks++; if (bus.o_seg !== 8'hFF) begin n_fail++; $display("FAIL mrst_seg got %h exp ff", bus.o_seg); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready got %b exp 1", bus.o_ready); end
    n_checks++; if (bus.o_nibble !== 4'h0) begin n_fail++; $display("FAIL mrst_nibble got %h exp 0", bus.o_nibble); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2 || c == 10) begin
        n_checks++;
        if (bus.o_dig !== ((c == 1) ? 4'hF : (c == 2) ? 4'b1110 : 4'b1101)) begin
          n_fail++; $display("FAIL mrst_resume cycle=%0d got %b", c, bus.o_dig);
        end
      end
      if (c == 2 * FRAME + 1) begin
        n_checks++;
        if (bus.o_nibble !== 4'h0) begin n_fail++; $display("FAIL mrst_pending_discarded got %h exp 0", bus.o_nibble); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load(16'h1234);
    test_back_to_back();
    test_blank();
    test_boundary_load();
    test_lz();
    test_random();
    test_midslot_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
